// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-add multiplier with a valid/ready handshake
// on both sides. Operands are converted to magnitudes on acceptance and
// multiplied over WIDTH cycles, one multiplier bit per cycle. The sign is
// applied when the result is latched.
//
// Parameters:
//   WIDTH      operand width (4..16)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand request
//   in_ready   controller idle, can accept a request
//   a, b       multiplicand / multiplier
//   signed_op  1 = operands are two's complement, 0 = unsigned
//   out_valid  product available
//   out_ready  consumer accepts product
//   product    2*WIDTH-bit result, held until the next completion
//   busy       high while running or holding a result
//
// Optional feature: define SEQ_MULT_EARLY_TERM_EN to finish as soon as all
// remaining multiplier bits are zero; the product value is unchanged.
module seq_mult_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc;
  logic               neg;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     acc_add;
  logic [WIDTH:0]     acc_nxt;
  logic [WIDTH-1:0]   mplier_nxt;
  logic [2*WIDTH-1:0] p_full;
  logic [2*WIDTH-1:0] p_aligned;
  logic [2*WIDTH-1:0] p_signed;
  logic               last_step;

  // The most negative value negates to itself, which is the correct
  // magnitude when read back as WIDTH unsigned bits.
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  always_comb begin
    acc_add    = mplier[0] ? (acc + {1'b0, mcand}) : acc;
    acc_nxt    = acc_add >> 1;
    mplier_nxt = {acc_add[0], mplier[WIDTH-1:1]};
    // The accumulator top bit is always 0 after the shift.
    p_full     = {acc_nxt[WIDTH-1:0], mplier_nxt};
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [CW-1:0] rem;

  // rem = multiplier bits not yet processed after this step; they sit in the
  // low rem bits of mplier_nxt.
  always_comb begin
    rem       = CW'(WIDTH - 1) - cnt;
    last_step = ((mplier_nxt << (CW'(WIDTH) - rem)) == '0);
    p_aligned = p_full >> rem;
  end
`else
  always_comb begin
    last_step = (cnt == CW'(WIDTH - 1));
    p_aligned = p_full;
  end
`endif

  assign p_signed = neg ? -p_aligned : p_aligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            acc      <= '0;
            neg      <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt      <= '0;
            state    <= StRun;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StRun: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            product   <= p_signed;
            state     <= StDone;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl (WIDTH = 8): directed corner cases,
// a mid-run reset, then random requests with random backpressure, all
// checked against an arithmetic reference model.
module tb_seq_mult_ctrl;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .signed_op (signed_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    int r;
    r = sval(x, s) * sval(y, s);
    return r[2*W-1:0];
  endfunction

  // Edges from acceptance to out_valid.
  function automatic int ref_lat(input logic [W-1:0] y, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int m;
    int n;
    m = sval(y, s);
    if (m < 0) m = -m;
    n = 1;
    while ((m >> n) != 0) n++;
    return n;
`else
    return W;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input int hold);
    logic [2*W-1:0] exp;
    int n;
    exp = ref_mul(x, y, s);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = x; b = y; signed_op = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // Inputs outside IDLE must be ignored.
    a = W'($urandom); b = W'($urandom); signed_op = 1'($urandom);
    check("busy_run", {30'd0, busy, in_ready}, 32'd2);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(ref_lat(y, s)));
    check("product", 32'(product), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      step();
      check("hold_state", {29'd0, out_valid, in_ready, busy}, 32'b101);
      check("hold_product", 32'(product), 32'(exp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("post_hs_product", 32'(product), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_op = 1'b0;
    #12;
    check("rst_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("rst_product", 32'(product), 32'd0);
    reset = 1'b0;
    step();

    do_mult(8'hFF, 8'hFF, 1'b0, 0);
    check("ff_ff_val", 32'(product), 32'h0000FE01);
    do_mult(8'h80, 8'h80, 1'b1, 1);
    check("80_80_val", 32'(product), 32'h00004000);
    do_mult(8'hFD, 8'h05, 1'b1, 5);
    check("fd_05_val", 32'(product), 32'h0000FFF1);
    do_mult(8'h25, 8'h01, 1'b0, 2);
    check("25_01_val", 32'(product), 32'h00000025);
    do_mult(8'h00, 8'h80, 1'b1, 0);
    check("0_80_val", 32'(product), 32'h00000000);
    do_mult(8'h80, 8'h7F, 1'b1, 0);
    do_mult(8'h01, 8'h00, 1'b0, 0);

    // Reset during RUN step 3.
    a = 8'h12; b = 8'h34; signed_op = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("midrun_rst_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("midrun_rst_product", 32'(product), 32'd0);
    #3;
    reset = 1'b0;
    step(); step(); step();
    do_mult(8'h12, 8'h34, 1'b0, 0);
    check("12_34_val", 32'(product), 32'h000003A8);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = W'($urandom_range(0, 3));
      do_mult(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; legal range 4..16.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand request.
REQ-005 SHALL have port in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port signed_op  input  1  1 = treat a and b as two's complement; 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  product available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts product.
REQ-011 SHALL have port product  output  2*WIDTH  result, two's complement when signed_op was 1.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 In IDLE, in_valid & in_ready at an edge SHALL capture the following and enter RUN:
- mcand = |a| and mplier = |b|, where magnitude applies only if signed_op and the MSB is 1;
- neg = signed_op & (a[MSB] ^ b[MSB]);
- upper accumulator (WIDTH+1 bits) = 0;
- step count = 0.
REQ-015 Each RUN cycle SHALL perform one shift-add step:
- if the current product-register LSB is 1, add mcand into the upper accumulator;
- shift the {accumulator, mplier} register right by 1;
- increment the step count.
REQ-016 After the WIDTH-th RUN step, the FSM SHALL enter DONE with product = neg ? -P : P, where P is the 2*WIDTH-bit magnitude product; accept at edge k gives out_valid at edge k+WIDTH.
REQ-017 Negating a zero magnitude SHALL yield 0.
REQ-018 Signed -2^(WIDTH-1) operands SHALL use magnitude 2^(WIDTH-1) in WIDTH unsigned bits; product SHALL be exact.
REQ-019 In DONE, product and out_valid SHALL hold stable until out_valid & out_ready; at that edge the FSM SHALL return to IDLE.
REQ-020 in_ready SHALL be 0 in DONE even when out_ready is 1; the next request is accepted no earlier than the edge after the handshake.
REQ-021 in_valid, a, b and signed_op SHALL be ignored outside IDLE.
REQ-022 product SHALL retain its last value in IDLE and RUN; it updates only on entry to DONE.

Reset
REQ-023 reset SHALL force state IDLE, in_ready=1, out_valid=0, busy=0, product=0, and clear all internal registers, including when asserted mid-RUN or in DONE.
REQ-024 The first request after reset deassertion SHALL be accepted at the first edge with in_valid=1.

Configuration
REQ-025 Macro SEQ_MULT_EARLY_TERM_EN SHALL control early termination.
REQ-026 With SEQ_MULT_EARLY_TERM_EN defined:
- after any RUN step, if all unprocessed multiplier bits are 0, the FSM SHALL enter DONE on that edge;
- P SHALL be aligned by shifting right by the remaining step count;
- minimum RUN length is 1 cycle;
- the product value SHALL be identical to the non-terminated result.
REQ-027 Without SEQ_MULT_EARLY_TERM_EN, RUN SHALL always last exactly WIDTH cycles, with no early-exit logic synthesized.

Verification
REQ-028 WIDTH=8, signed_op=0, a=0xFF, b=0xFF -> out_valid 8 edges after accept, product=0xFE01.
REQ-029 signed_op=1, a=0x80, b=0x80 -> product=0x4000; a=0xFD, b=0x05 -> product=0xFFF1.
REQ-030 Backpressure: out_ready held 0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0 and in_valid ignored; handshake edge -> IDLE, in_ready=1 next cycle.
REQ-031 reset pulse at RUN step 3 -> all outputs at reset values immediately; a new request 3 cycles later completes correctly (0x12*0x34 unsigned = 0x03A8).
REQ-032 SEQ_MULT_EARLY_TERM_EN defined, a=0x25, b=0x01 -> out_valid 1 edge after accept, product=0x0025; macro undefined -> 8 edges, same product.
REQ-033 a=0, b=0x80, signed_op=1 -> product=0x0000 with no negative-zero artifact.
